// File: rtl/pflink_crc8_arbiter.sv
// Round-robin, packet-locked arbiter sharing one CRC8 (x^8+x^2+x+1) tagger across N_REQ link-word sources.
// Define CRC8_PKT_CHAIN_EN to chain each word's CRC seed across the packet (default: per-word CRC, seed 0).

module pflink_crc8 (
  input  logic [7:0]  seed,
  input  logic [12:0] data,
  output logic [7:0]  crc
);
  // Serial MSB-first update unrolled: d[12] enters first.
  always_comb begin
    logic [7:0] c;
    c = seed;
    for (int i = 12; i >= 0; i--)
      c = {c[6:0], 1'b0} ^ ({8{c[7] ^ data[i]}} & 8'h07);
    crc = c;
  end
endmodule

module pflink_crc8_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [13*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [20:0]        out_data,
  output logic [ID_W-1:0]    out_src,
  output logic               out_last,
  output logic               timeout_err,
  output logic [7:0]         timeout_cnt
);
  localparam int SW = $clog2(TIMEOUT_CYC + 2);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, nxt;
  logic [ID_W-1:0] gnt, rr_ptr, pick, gnt_inc;
  logic [SW-1:0]   stall_cnt;
  logic            any_valid, sel_valid, sel_last, buf_free, accept, stall, expire;
  logic [12:0]     sel_data;
  logic [7:0]      seed, crc;

  assign any_valid = |req_valid;
  assign sel_valid = req_valid[gnt];
  assign sel_last  = req_last[gnt];
  assign sel_data  = req_data[13*gnt +: 13];
  assign buf_free  = !out_valid || out_ready;
  assign accept    = (state == BUSY) && sel_valid && buf_free;
  assign stall     = (state == BUSY) && !sel_valid;
  assign expire    = (TIMEOUT_CYC != 0) && stall && (stall_cnt == SW'(TIMEOUT_CYC - 1));
  assign gnt_inc   = ID_W'((int'(gnt) + 1) % N_REQ);

  // First requesting index at or above rr_ptr, wrapping.
  always_comb begin
    int  idx;
    logic found;
    pick  = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req_valid[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  pflink_crc8 u_crc (.seed(seed), .data(sel_data), .crc(crc));

`ifdef CRC8_PKT_CHAIN_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                            seed <= 8'h00;
    else if (state == IDLE && any_valid)   seed <= 8'h00;
    else if (accept)                       seed <= crc;
`else
  assign seed = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (any_valid) nxt = BUSY;
      BUSY: if ((accept && sel_last) || expire) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == BUSY) req_ready[gnt] = buf_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      rr_ptr      <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
      timeout_cnt <= 8'h00;
    end else begin
      timeout_err <= expire;
      if (state == IDLE && any_valid) begin
        gnt       <= pick;
        stall_cnt <= '0;
      end else if (accept) begin
        stall_cnt <= '0;
        if (sel_last) rr_ptr <= gnt_inc;
      end else if (stall && TIMEOUT_CYC != 0) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (expire) begin
        rr_ptr <= gnt_inc;
        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'h01;
      end
    end
  end

  // Single-stage output buffer; holds until the downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= {crc, sel_data};
      out_src   <= gnt;
      out_last  <= sel_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pflink_crc8_arbiter.sv
// Directed bench for pflink_crc8_arbiter (N_REQ=4, TIMEOUT_CYC=5); chained-CRC expectations follow CRC8_PKT_CHAIN_EN.
module tb_pflink_crc8_arbiter;
  localparam int N = 4;

`ifdef CRC8_PKT_CHAIN_EN
  localparam logic [20:0] CHAIN_EXP = 21'h15C000;
  localparam logic [20:0] BP_EXP    = 21'h1F3000;
`else
  localparam logic [20:0] CHAIN_EXP = 21'h000000;
  localparam logic [20:0] BP_EXP    = 21'h0AF000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [13*N-1:0] req_data;
  logic          out_valid, out_ready, out_last, timeout_err;
  logic [20:0]   out_data;
  logic [1:0]    out_src;
  logic [7:0]    timeout_cnt;
  int            errs = 0, checks = 0;

  pflink_crc8_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT_CYC(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .out_last(out_last), .timeout_err(timeout_err), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [12:0] d, input logic l);
    req_valid[i]        = v;
    req_data[13*i +: 13] = d;
    req_last[i]         = l;
  endtask

  task automatic drop_all();
    req_valid = '0; req_last = '0; req_data = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_ov"},    out_valid, 0);
    chk({tag, "_od"},    out_data, 0);
    chk({tag, "_src"},   out_src, 0);
    chk({tag, "_last"},  out_last, 0);
    chk({tag, "_terr"},  timeout_err, 0);
    chk({tag, "_tcnt"},  timeout_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; drop_all();
    tick(); tick();
    chk_zero("rst");
    rst_n = 1'b1;
    tick();

    // single word from requester 2
    set_req(2, 1, 13'h0001, 1);
    #1 chk("idle_ready", req_ready, 0);
    tick();
    chk("sw_ready", req_ready, 4'b0100);
    chk("sw_ov_e1", out_valid, 0);
    tick();
    drop_all();
    #1;
    chk("sw_ov", out_valid, 1);
    chk("sw_data", out_data, 21'h00E001);
    chk("sw_src", out_src, 2);
    chk("sw_last", out_last, 1);
    chk("sw_idle_ready", req_ready, 0);
    tick();
    chk("sw_drain", out_valid, 0);

    // pointer now at 3: requester 3 beats 0
    set_req(0, 1, 13'h0001, 1);
    set_req(3, 1, 13'h0000, 1);
    tick();
    chk("rr3_ready", req_ready, 4'b1000);
    tick();
    drop_all();
    chk("rr3_src", out_src, 3);
    tick();

    // round robin, one bubble between packets
    for (int i = 0; i < N; i++) set_req(i, 1, 13'h0001, 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("rr_ov%0d", k), out_valid, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) chk($sformatf("rr_src%0d", k), out_src, ((k / 2) - 1) % 4);
    end
    drop_all();
    tick();

    // watchdog: requester 1 stalls after one non-last word
    set_req(1, 1, 13'h1000, 0);
    tick();
    tick();
    drop_all();
    chk("wd_data", out_data, 21'h0AF000);
    chk("wd_last", out_last, 0);
    chk("wd_src", out_src, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("wd_early%0d", k), timeout_err, 0);
    end
    chk("wd_drained", out_valid, 0);
    tick();
    chk("wd_pulse", timeout_err, 1);
    chk("wd_cnt", timeout_cnt, 1);
    for (int i = 0; i < 3; i++) set_req(i, 1, 13'h0001, 1);
    tick();
    chk("wd_pulse_end", timeout_err, 0);
    chk("wd_next_ready", req_ready, 4'b0100);
    tick();
    drop_all();
    chk("wd_next_src", out_src, 2);
    chk("wd_next_data", out_data, 21'h00E001);
    tick();

    // two-word packet from requester 0
    set_req(0, 1, 13'h0001, 0);
    tick();
    tick();
    set_req(0, 1, 13'h0000, 1);
    chk("ch_w0", out_data, 21'h00E001);
    chk("ch_l0", out_last, 0);
    tick();
    drop_all();
    chk("ch_w1", out_data, CHAIN_EXP);
    chk("ch_l1", out_last, 1);
    tick();
    chk("ch_drain", out_valid, 0);

    // backpressure for 10 cycles mid-packet
    out_ready = 1'b0;
    set_req(1, 1, 13'h0001, 0);
    tick();
    tick();
    set_req(1, 1, 13'h1000, 1);
    #1 chk("bp_ready0", req_ready, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("bp_hold%0d", k), out_data, 21'h00E001);
      chk($sformatf("bp_ov%0d", k), out_valid, 1);
      chk($sformatf("bp_rdy%0d", k), req_ready, 0);
      chk($sformatf("bp_terr%0d", k), timeout_err, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release", req_ready, 4'b0010);
    tick();
    drop_all();
    chk("bp_w1", out_data, BP_EXP);
    chk("bp_l1", out_last, 1);
    tick();
    chk("bp_drain", out_valid, 0);
    chk("bp_tcnt", timeout_cnt, 1);

    // async reset with a word in the buffer
    out_ready = 1'b0;
    set_req(3, 1, 13'h0001, 0);
    tick();
    tick();
    chk("ar_ov", out_valid, 1);
    #3 rst_n = 1'b0;
    #1 chk_zero("ar");
    drop_all();
    tick();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    set_req(1, 1, 13'h1000, 1);
    set_req(3, 1, 13'h1000, 1);
    tick();
    tick();
    drop_all();
    chk("ar_src", out_src, 1);
    chk("ar_data", out_data, 21'h0AF000);
    chk("ar_last", out_last, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
